ayatsuki_uart_rx: RTL and testbench
===================================

AYATSUKI_UART_RX -- requirements
Module: ayatsuki_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port uart_rx, input, 1, serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data, output, 8, FIFO head byte (first-word fall-through).
REQ-007 SHALL have port rx_valid, output, 1, high while the FIFO is non-empty.
REQ-008 SHALL have port rx_ready, input, 1, consumer accept; a pop occurs when rx_valid and rx_ready are both high.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer preset to 1; all detection uses the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH; reset state IDLE.
REQ-013 IDLE SHALL move to START on a synchronized 1->0 transition and load the bit counter with CLKS_PER_BIT/2-1.
REQ-014 START SHALL sample the line when the counter reaches 0: low -> DATA with counter CLKS_PER_BIT-1; high -> IDLE (glitch rejected, no output).
REQ-015 DATA SHALL sample once every CLKS_PER_BIT cycles at mid-bit, shift LSB first, and move to STOP after the 8th sample.
REQ-016 STOP SHALL sample after CLKS_PER_BIT cycles: high -> push byte, go IDLE; low -> frame_err pulse, discard byte, go WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL return to IDLE on the first synchronized high sample; no start detection occurs while in WAIT_HIGH.
REQ-018 A pushed byte SHALL appear on rx_data with rx_valid high on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-019 A push to a full FIFO without a simultaneous pop SHALL drop the new byte, keep FIFO contents unchanged, and pulse overrun.
REQ-020 A simultaneous push and pop on a full FIFO SHALL succeed for both, with no overrun.
REQ-021 A pop on an empty FIFO SHALL be ignored, since rx_valid is low.
REQ-022 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; full/empty SHALL be decided by MSB comparison.
REQ-023 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, with no wrap within a bit period.
REQ-024 rx_data SHALL hold its value while rx_valid is high and rx_ready is low.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: FSM IDLE, synchronizer 1, counters 0, FIFO empty, rx_valid 0, rx_data 8'h00, frame_err 0, overrun 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release, the first 1->0 transition begins a new frame.

Structure
REQ-027 FSM state encoding and the default values of CLKS_PER_BIT and FIFO_DEPTH SHALL reside in shared header ayatsuki_uart_defs, also used by the UART transmitter.
REQ-028 The FIFO SHALL be a sub-module ayatsuki_sync_fifo (parameterized width/depth, push/pop/full/empty); the FSM and synchronizer SHALL stay in ayatsuki_uart_rx.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-029 Frame 0xA5 with a valid stop, rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=8'hA5, frame_err=0.
REQ-030 Low pulse of 3 cycles on an idle line -> no rx_valid and no frame_err; a following 0x3C frame is received correctly.
REQ-031 Frame 0x55 with stop bit low -> frame_err pulse 1 cycle, FIFO empty; line held low 20 cycles then 0x81 sent -> 0x81 received.
REQ-032 Five frames 0x01..0x05 with rx_ready=0 -> overrun pulses once, on frame 5; then rx_ready=1 -> pops yield 0x01..0x04 in order.
REQ-033 rst_n low during the DATA state of frame 0xFF, released, then 0x12 sent -> only 0x12 received.
REQ-034 FIFO full, 5th stop-bit push in the same cycle as a pop -> no overrun, FIFO stays full, 5th byte read last.

Source files
------------

// File: rtl/ayatsuki_uart_defs.sv
// Shared UART definitions used by the receiver and the transmitter:
// FSM state encoding and default line/buffer parameters.
package ayatsuki_uart_defs;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int UART_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Countdown reload that lands the first sample in the middle of a bit.
    function automatic int half_bit(input int clks);
        return clks / 2 - 1;
    endfunction

endpackage

// File: rtl/ayatsuki_sync_fifo.sv
// Synchronous first-word fall-through FIFO with wrap-bit pointers.
// Head data reads as zero while the FIFO is empty.
module ayatsuki_sync_fifo
    import ayatsuki_uart_defs::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot with differing wrap bits means the writer lapped the reader.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ayatsuki_uart_rx.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling FSM and
// a first-word fall-through receive FIFO with overrun/frame error pulses.
module ayatsuki_uart_rx
    import ayatsuki_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      r_state;
    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_rx;
    logic             w_fall;
    logic             w_tick;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], uart_rx};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_rx) begin
                        r_state   <= ST_DATA;
                        r_cnt     <= CNT_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= CNT_FULL;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state     <= ST_WAIT_HIGH;
                        r_frame_err <= 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low break must end before a new start is trusted.
                    if (w_rx) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_push = (r_state == ST_STOP) & w_tick & w_rx;
    assign w_pop  = rx_ready & rx_valid;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
        end
    end

    ayatsuki_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (rx_ready),
        .o_rdata (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_ayatsuki_uart_rx.sv
// Directed bench for ayatsuki_uart_rx with a frame-level reference model.
module tb_ayatsuki_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    // Edge offset from the first start-bit edge to the stop-bit decision.
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         model_on = 1'b0;
    logic       rdy_e = 1'b0;
    logic       rdy_base = 1'b0;

    ev_t        sched[$];
    logic [7:0] mq[$];
    logic [7:0] plog[$];
    int         n_valid = 0;
    int         n_fe = 0;
    int         n_ov = 0;

    ayatsuki_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_e = rx_ready;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model and per-cycle compare, evaluated after each edge.
    always @(negedge clk) begin
        bit  pop;
        bit  exp_fe;
        bit  exp_ov;
        ev_t ev;
        if (model_on) begin
            pop    = rdy_e && (mq.size() > 0);
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            if (pop) void'(mq.pop_front());
            while (sched.size() > 0 && sched[0].t <= cyc) begin
                ev = sched.pop_front();
                if (!ev.ok)                 exp_fe = 1'b1;
                else if (mq.size() == DEPTH) exp_ov = 1'b1;
                else                        mq.push_back(ev.b);
            end
            check("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
            check("frame_err", 32'(frame_err), 32'(exp_fe));
            check("overrun", 32'(overrun), 32'(exp_ov));
        end
        if (rx_valid) n_valid++;
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (rx_valid && rx_ready) plog.push_back(rx_data);
    end

    function automatic logic lvl(input logic [7:0] b, input logic s,
                                 input int j);
        int idx;
        idx = j / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic level = 1'b1);
        for (int i = 0; i < n; i++) begin
            uart_rx  = level;
            rx_ready = rdy_base;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit pop_at_push = 1'b0);
        sched.push_back('{cyc + 1 + LAT, b, bit'(stop_bit)});
        for (int j = 0; j < 10 * CPB; j++) begin
            uart_rx  = lvl(b, stop_bit, j);
            rx_ready = (pop_at_push && j == LAT) ? 1'b1 : rdy_base;
            tick();
        end
        uart_rx  = 1'b1;
        rx_ready = rdy_base;
    endtask

    task automatic clr();
        n_valid = 0;
        n_fe    = 0;
        n_ov    = 0;
        plog.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst_n    = 1'b1;
        model_on = 1'b1;
        idle(10);

        // Single good frame, consumer always ready.
        clr();
        rdy_base = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(6);
        check("a5 valid cycles", 32'(n_valid), 32'd1);
        check("a5 pops", 32'(plog.size()), 32'd1);
        if (plog.size() > 0) check("a5 data", 32'(plog[0]), 32'hA5);
        check("a5 frame_err", 32'(n_fe), 32'd0);

        // Short glitch, then a real frame.
        clr();
        idle(3, 1'b0);
        idle(12);
        check("glitch valid", 32'(n_valid), 32'd0);
        check("glitch frame_err", 32'(n_fe), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle(6);
        check("3c pops", 32'(plog.size()), 32'd1);
        if (plog.size() > 0) check("3c data", 32'(plog[0]), 32'h3C);

        // Bad stop bit, line held low, recovery.
        clr();
        send_frame(8'h55, 1'b0);
        idle(20, 1'b0);
        idle(16);
        check("55 frame_err count", 32'(n_fe), 32'd1);
        check("55 valid", 32'(n_valid), 32'd0);
        send_frame(8'h81, 1'b1);
        idle(6);
        check("81 pops", 32'(plog.size()), 32'd1);
        if (plog.size() > 0) check("81 data", 32'(plog[0]), 32'h81);

        // Five frames into a four-entry FIFO with no consumer.
        clr();
        rdy_base = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            idle(4);
        end
        check("ovr count", 32'(n_ov), 32'd1);
        check("ovr no pops", 32'(plog.size()), 32'd0);
        rdy_base = 1'b1;
        idle(8);
        check("drain count", 32'(plog.size()), 32'd4);
        for (int i = 0; i < 4 && i < plog.size(); i++)
            check("drain data", 32'(plog[i]), 32'(i + 1));
        check("ovr count after", 32'(n_ov), 32'd1);

        // Reset in the middle of a frame's data bits.
        clr();
        sched.delete();
        for (int j = 0; j < 40; j++) begin
            uart_rx  = lvl(8'hFF, 1'b1, j);
            rx_ready = rdy_base;
            tick();
        end
        rst_n    = 1'b0;
        model_on = 1'b0;
        sched.delete();
        mq.delete();
        #1;
        check("midrst rx_valid", 32'(rx_valid), 32'd0);
        check("midrst frame_err", 32'(frame_err), 32'd0);
        idle(3);
        rst_n    = 1'b1;
        model_on = 1'b1;
        idle(10);
        send_frame(8'h12, 1'b1);
        idle(6);
        check("rst pops", 32'(plog.size()), 32'd1);
        if (plog.size() > 0) check("rst data", 32'(plog[0]), 32'h12);

        // Full FIFO, fifth push coincides with a pop.
        clr();
        rdy_base = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(4);
        send_frame(8'h33, 1'b1);
        idle(4);
        send_frame(8'h44, 1'b1);
        idle(4);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(4);
        check("sim ovr", 32'(n_ov), 32'd0);
        check("sim still valid", 32'(rx_valid), 32'd1);
        rdy_base = 1'b1;
        idle(8);
        check("sim pop count", 32'(plog.size()), 32'd5);
        if (plog.size() == 5) begin
            check("sim pop0", 32'(plog[0]), 32'h11);
            check("sim pop1", 32'(plog[1]), 32'h22);
            check("sim pop4 last", 32'(plog[4]), 32'h55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
